rx_lp_ctrl_fsm: RTL and testbench
=================================

# rx_lp_ctrl_fsm

C-PHY receiver low-power line-state controller. Gates and consumes the 2-bit LP control decoder output, deglitches it, and sequences the lane through init, stop, HS-request, bridge/settle, HS-active and LP-request phases. Drives HS termination and HS receiver enables for the downstream HS datapath, and flags illegal LP sequences.

## Interface
- DEB_CYCLES, 2: consecutive identical samples needed before a decoder code is valid (≥1)
- INIT_CYCLES, 16: stable-stop cycles required to leave INIT
- SETTLE_CYCLES, 8: cycles spent in HS_SETTLE before HS_ACTIVE (≥1)
- RQST_TIMEOUT, 32: max cycles in HS_RQST without a valid bridge code
- CNT_W, 8: counter width; all cycle parameters ≤ 2^CNT_W−1
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- Enable  input  1  lane enable; 0 forces IDLE
- CtrlDecoderOut  input  2  decoded LP code: 00 stop, 01 HS request, 10 bridge, 11 LP request/other
- CtrlDecoderEn  output  1  decoder enable, registered
- HsTermEn  output  1  HS termination enable
- HsRxEn  output  1  HS receiver/datapath enable
- LpRqst  output  1  high while in LP_RQST (escape/turnaround handled downstream)
- ErrSeq  output  1  one-cycle pulse on sequence error or timeout
- RxState  output  3  current state encoding

## Operation
- States/encoding: IDLE 0, INIT 1, STOP 2, HS_RQST 3, HS_SETTLE 4, HS_ACTIVE 5, LP_RQST 6, ERR_WAIT 7.
- Deglitch: CodeReg holds last sampled code, StableCnt (saturating at 2^CNT_W−1). Sample differs from CodeReg → CodeReg ← sample, StableCnt ← 1; equal → StableCnt+1. Code valid when StableCnt ≥ DEB_CYCLES. StableCnt and CodeReg cleared (0) while CtrlDecoderEn = 0, so disabled-decoder output (00) is never accepted.
- PhaseCnt: cleared on every state change, increments each cycle otherwise; used for settle and timeout.
- Transitions (all registered; "valid X" = valid code X):
  - Enable = 0 in any state → IDLE; overrides everything except reset.
  - IDLE: Enable = 1 → INIT.
  - INIT: CodeReg = 00 and StableCnt ≥ INIT_CYCLES → STOP; other codes ignored.
  - STOP: valid 01 → HS_RQST; valid 11 → LP_RQST; valid 10 → ERR_WAIT + ErrSeq.
  - HS_RQST: valid 10 → HS_SETTLE; valid 00 → STOP (no error); valid 11 → ERR_WAIT + ErrSeq; PhaseCnt = RQST_TIMEOUT−1 with no valid 10/00/11 → ERR_WAIT + ErrSeq. Valid code wins over timeout in the same cycle.
  - HS_SETTLE: PhaseCnt = SETTLE_CYCLES−1 → HS_ACTIVE; valid 00 before that → STOP + ErrSeq (aborted burst); other codes ignored. Valid 00 and settle-done in same cycle → STOP + ErrSeq.
  - HS_ACTIVE: valid 00 → STOP (end of burst); other codes ignored.
  - LP_RQST: valid 00 → STOP; others ignored.
  - ERR_WAIT: valid 00 → STOP.
- Outputs (registered, decoded from next state): CtrlDecoderEn = 1 in all states but IDLE; HsTermEn = 1 in HS_SETTLE, HS_ACTIVE; HsRxEn = 1 in HS_ACTIVE; LpRqst = 1 in LP_RQST; RxState = state.

## Timing
- Reset (rst_n = 0 at edge): state IDLE, all outputs 0, RxState 0, counters/CodeReg 0. Reset mid-burst drops HsRxEn/HsTermEn on that edge.
- Enable rising sampled at edge k → INIT and CtrlDecoderEn = 1 after edge k; first decoder sample taken at edge k+1.
- Code first sampled at edge k (StableCnt = 1) → resulting state change visible after edge k+DEB_CYCLES.
- INIT exit: stop first sampled at edge k → STOP after edge k+INIT_CYCLES.
- HS_SETTLE entered at edge e → HS_ACTIVE, HsRxEn = 1 after edge e+SETTLE_CYCLES.
- HS_RQST entered at edge e with no valid code → ERR_WAIT, ErrSeq high for the cycle after edge e+RQST_TIMEOUT.
- ErrSeq is exactly one cycle; asserted concurrently with the state change it reports.
- Glitch shorter than DEB_CYCLES samples: no state change, StableCnt restarts for returned code.

## Test plan
- Reset then Enable = 1, decoder 00 held: CtrlDecoderEn = 1 next cycle, RxState 1 → 2 after 16 samples, all other outputs 0.
- Full HS entry/exit: STOP, 01 ×2, 10 ×2 → HS_SETTLE, HsTermEn = 1; 8 cycles later HsRxEn = 1; then 00 ×2 → STOP, HsRxEn/HsTermEn = 0, no ErrSeq.
- Glitch rejection: in STOP, 01 for 1 cycle then 00: RxState stays 2; DEB_CYCLES = 1 build: same stimulus → HS_RQST.
- HS request timeout: STOP, 01 ×2, then 01 held 32 cycles → ERR_WAIT, single ErrSeq pulse; 00 ×2 → STOP.
- Sequence errors: STOP + 10 ×2 → ERR_WAIT + ErrSeq; HS_SETTLE + 00 ×2 at settle cycle 3 → STOP + ErrSeq, HsRxEn never asserted.
- Enable = 0 during HS_ACTIVE → IDLE next edge, all outputs 0; rst_n = 0 during HS_SETTLE → same; LP path: STOP + 11 ×2 → LpRqst = 1, 00 ×2 → LpRqst = 0.

Source files
------------

// File: rtl/rx_lp_ctrl_fsm.sv
// rx_lp_ctrl_fsm: C-PHY LP line-state controller; in: clk, rst_n, Enable, CtrlDecoderOut; out: CtrlDecoderEn, HsTermEn, HsRxEn, LpRqst, ErrSeq, RxState
module rx_lp_ctrl_fsm #(
  parameter int DEB_CYCLES    = 2,
  parameter int INIT_CYCLES   = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int RQST_TIMEOUT  = 32,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Enable,
  input  logic [1:0] CtrlDecoderOut,
  output logic       CtrlDecoderEn,
  output logic       HsTermEn,
  output logic       HsRxEn,
  output logic       LpRqst,
  output logic       ErrSeq,
  output logic [2:0] RxState
);
  typedef enum logic [2:0] {IDLE, INIT, STOP, HS_RQST, HS_SETTLE, HS_ACTIVE, LP_RQST, ERR_WAIT} state_t;
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] DEB_C       = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] INIT_C      = CNT_W'(INIT_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RQST_LAST   = CNT_W'(RQST_TIMEOUT - 1);
  state_t           state_q, state_d;
  logic [1:0]       code_q, code_d;
  logic [CNT_W-1:0] stable_q, stable_d, phase_q, phase_d;
  logic             en_q, term_q, rx_q, lp_q, err_q, err_d, valid;
  always_comb begin
    code_d   = en_q ? CtrlDecoderOut : 2'b00;
    stable_d = !en_q ? '0 :
               (CtrlDecoderOut != code_q) ? CNT_W'(1) :
               (stable_q == CNT_MAX) ? stable_q : stable_q + 1'b1;
    valid    = stable_q >= DEB_C;
    state_d  = state_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: state_d = INIT;
      INIT: state_d = (code_q == 2'b00 && stable_q >= INIT_C) ? STOP : INIT;
      STOP: if (valid && code_q != 2'b00) begin
        state_d = code_q == 2'b01 ? HS_RQST : code_q == 2'b11 ? LP_RQST : ERR_WAIT;
        err_d   = code_q == 2'b10;
      end
      HS_RQST: if (valid && code_q != 2'b01) begin
        state_d = code_q == 2'b10 ? HS_SETTLE : code_q == 2'b00 ? STOP : ERR_WAIT;
        err_d   = code_q == 2'b11;
      end else if (phase_q == RQST_LAST) begin
        state_d = ERR_WAIT;
        err_d   = 1'b1;
      end
      HS_SETTLE: if (valid && code_q == 2'b00) begin
        state_d = STOP;
        err_d   = 1'b1;
      end else if (phase_q == SETTLE_LAST) begin
        state_d = HS_ACTIVE;
      end
      HS_ACTIVE, LP_RQST, ERR_WAIT: state_d = (valid && code_q == 2'b00) ? STOP : state_q;
    endcase
    if (!Enable) begin
      state_d = IDLE;
      err_d   = 1'b0;
    end
    phase_d = (state_d != state_q) ? '0 : (phase_q == CNT_MAX) ? phase_q : phase_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      code_q   <= 2'b00;
      stable_q <= '0;
      phase_q  <= '0;
      en_q     <= 1'b0;
      term_q   <= 1'b0;
      rx_q     <= 1'b0;
      lp_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      stable_q <= stable_d;
      phase_q  <= phase_d;
      en_q     <= state_d != IDLE;
      term_q   <= state_d == HS_SETTLE || state_d == HS_ACTIVE;
      rx_q     <= state_d == HS_ACTIVE;
      lp_q     <= state_d == LP_RQST;
      err_q    <= err_d;
    end
  end
  assign CtrlDecoderEn = en_q;
  assign HsTermEn      = term_q;
  assign HsRxEn        = rx_q;
  assign LpRqst        = lp_q;
  assign ErrSeq        = err_q;
  assign RxState       = state_q;
endmodule

// File: tb/tb_rx_lp_ctrl_fsm.sv
// tb_rx_lp_ctrl_fsm: scoreboard bench for rx_lp_ctrl_fsm with a DEB_CYCLES=1 companion instance
module tb_rx_lp_ctrl_fsm;
  logic clk = 1'b0, rst_n, en;
  logic [1:0] code;
  logic d0_en, d0_term, d0_rx, d0_lp, d0_err, d1_en, d1_term, d1_rx, d1_lp, d1_err;
  logic [2:0] d0_st, d1_st;
  int n = 0, pass = 0, total = 0;
  typedef struct {int e; bit d1; logic [7:0] v; string nm;} exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  always @(posedge clk) n <= n + 1;
  rx_lp_ctrl_fsm u_dut (
    .clk(clk), .rst_n(rst_n), .Enable(en), .CtrlDecoderOut(code),
    .CtrlDecoderEn(d0_en), .HsTermEn(d0_term), .HsRxEn(d0_rx), .LpRqst(d0_lp), .ErrSeq(d0_err), .RxState(d0_st)
  );
  rx_lp_ctrl_fsm #(.DEB_CYCLES(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .Enable(en), .CtrlDecoderOut(code),
    .CtrlDecoderEn(d1_en), .HsTermEn(d1_term), .HsRxEn(d1_rx), .LpRqst(d1_lp), .ErrSeq(d1_err), .RxState(d1_st)
  );
  function automatic logic [7:0] vec(input logic [2:0] st, input logic err);
    return {st, st != 3'd0, st == 3'd4 || st == 3'd5, st == 3'd5, st == 3'd6, err};
  endfunction
  task automatic push_x(input bit d1, input int k, input logic [2:0] st, input logic err, input string nm);
    exp_t x;
    x.e = n + k;
    x.d1 = d1;
    x.v = vec(st, err);
    x.nm = nm;
    q.push_back(x);
  endtask
  task automatic push(input int k, input logic [2:0] st, input logic err, input string nm);
    push_x(1'b0, k, st, err, nm);
  endtask
  task automatic drive(input logic r, input logic e, input logic [1:0] c, input int cycles);
    rst_n = r;
    en = e;
    code = c;
    repeat (cycles) @(posedge clk);
    #1;
  endtask
  initial begin : monitor
    exp_t x;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].e <= n) begin
        x = q.pop_front();
        act = x.d1 ? {d1_st, d1_en, d1_term, d1_rx, d1_lp, d1_err} : {d0_st, d0_en, d0_term, d0_rx, d0_lp, d0_err};
        total++;
        if (x.e != n) $display("FAIL %s: check missed at edge %0d (now %0d)", x.nm, x.e, n);
        else if (act !== x.v) $display("FAIL %s @edge %0d: got st=%0d en/term/rx/lp/err=%b, want st=%0d en/term/rx/lp/err=%b",
                                       x.nm, n, act[7:5], act[4:0], x.v[7:5], x.v[4:0]);
        else pass++;
      end
    end
  end
  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    code = 2'b00;
    push(1, 0, 0, "rst1");
    push(2, 0, 0, "rst2");
    drive(0, 0, 2'b00, 2);
    push(1, 1, 0, "init_entry");
    push(17, 1, 0, "init_hold");
    push(18, 2, 0, "stop_reached");
    drive(1, 1, 2'b00, 20);
    push(2, 2, 0, "rq_pending");
    push(3, 3, 0, "hs_rqst");
    push(5, 4, 0, "hs_settle");
    push(12, 4, 0, "settle_last");
    push(13, 5, 0, "hs_active");
    drive(1, 1, 2'b01, 2);
    drive(1, 1, 2'b10, 14);
    push(2, 5, 0, "burst_end_pend");
    push(3, 2, 0, "burst_end");
    push(4, 2, 0, "burst_no_err");
    drive(1, 1, 2'b00, 4);
    push(2, 2, 0, "glitch_a");
    push_x(1'b1, 2, 3, 0, "glitch_deb1");
    push(3, 2, 0, "glitch_b");
    push(5, 2, 0, "glitch_c");
    drive(1, 1, 2'b01, 1);
    drive(1, 1, 2'b00, 5);
    push(3, 3, 0, "to_rqst");
    push(34, 3, 0, "to_pre");
    push(35, 7, 1, "timeout_err");
    push(36, 7, 0, "timeout_single");
    drive(1, 1, 2'b01, 36);
    push(2, 7, 0, "errw_hold");
    push(3, 2, 0, "errw_exit");
    drive(1, 1, 2'b00, 4);
    push(3, 7, 1, "stop_bridge_err");
    push(4, 7, 0, "stop_bridge_pulse");
    drive(1, 1, 2'b10, 4);
    push(3, 2, 0, "err_recover");
    drive(1, 1, 2'b00, 4);
    push(5, 4, 0, "abort_settle");
    push(9, 4, 0, "abort_pre");
    push(10, 2, 1, "abort_err");
    push(11, 2, 0, "abort_pulse");
    drive(1, 1, 2'b01, 2);
    drive(1, 1, 2'b10, 5);
    drive(1, 1, 2'b00, 6);
    push(2, 2, 0, "lp_pend");
    push(3, 6, 0, "lp_rqst");
    drive(1, 1, 2'b11, 4);
    push(2, 6, 0, "lp_hold");
    push(3, 2, 0, "lp_exit");
    drive(1, 1, 2'b00, 4);
    push(13, 5, 0, "active2");
    drive(1, 1, 2'b01, 2);
    drive(1, 1, 2'b10, 12);
    push(1, 0, 0, "en_off");
    push(2, 0, 0, "en_off_hold");
    drive(1, 0, 2'b00, 2);
    push(1, 1, 0, "reinit");
    push(17, 1, 0, "reinit_hold");
    push(18, 2, 0, "restop");
    drive(1, 1, 2'b00, 20);
    push(5, 4, 0, "settle_pre_rst");
    drive(1, 1, 2'b01, 2);
    drive(1, 1, 2'b10, 4);
    push(1, 0, 0, "rst_mid_settle");
    push(2, 0, 0, "rst_hold");
    drive(0, 1, 2'b10, 2);
    push(1, 1, 0, "post_rst_init");
    drive(1, 1, 2'b00, 3);
    for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      total++;
      $display("FAIL drain: %0d checks left unchecked, want 0", q.size());
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
